aes_inv_key_schedule: RTL
=========================

AES_INV_KEY_SCHEDULE -- requirements
Module: aes_inv_key_schedule

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset  input  1  synchronous, active-low reset (sampled on posedge clk).
REQ-003 sel  input  2  key size, sampled on start: 00 -> AES-128 (Nk=4, Nr=10); 01 -> AES-192 (Nk=6, Nr=12); 10/11 -> AES-256 (Nk=8, Nr=14).
REQ-004 start  input  1  request a schedule run; honoured only in IDLE.
REQ-005 last_key  input  256  last Nk expanded-key words, right-aligned, w[j0] most significant in bits [32*Nk-1:32*Nk-32], where j0=4(Nr+1)-Nk (40/46/52); unused upper bits are ignored.
REQ-006 rk_ready  input  1  consumer accepts round_key this cycle.
REQ-007 rk_valid  output  1  round_key/round_idx are valid.
REQ-008 round_key  output  128  w[4r]||w[4r+1]||w[4r+2]||w[4r+3], with w[4r] in [127:96].
REQ-009 round_idx  output  4  r, the round number of round_key.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 done  output  1  one-cycle pulse after round 0 is accepted.

Function
REQ-012 FSM states: IDLE, RUN, DONE. IDLE->RUN on start; RUN->DONE on rk_valid&&rk_ready&&r==0; DONE->IDLE unconditionally after one cycle.
REQ-013 On the start edge: latch Nk/Nr from sel; load window W[k]=w[j0+k] for k<Nk; set j=j0, r=Nr, phase=3, rcon_idx=10/8/7 for 128/192/256.
REQ-014 rk_valid = (state==RUN && j<=4r), and is combinational from registered state; round_key = W[4r-j .. 4r-j+3]; offset 4r-j is always 0..Nk-4.
REQ-015 RUN with rk_valid&&rk_ready: r decrements; no window step in that cycle.
REQ-016 RUN with rk_valid=0: one backward step. New word = W[Nk-1] xor T(W[Nk-2]), shifted into W[0] (W[k+1]<=W[k]); j decrements.
REQ-017 T(x): if phase==0, T = SubWord(RotWord(x)) xor {Rcon[rcon_idx],24'h0}; else if Nk==8 and phase==4, T = SubWord(x); otherwise T = x. The block uses the forward S-box.
REQ-018 After each step, phase wraps from 0 to Nk-1, otherwise it decrements. rcon_idx decrements after every phase-0 step.
REQ-019 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
REQ-020 rk_valid held with rk_ready=0: round_key, round_idx and the window hold stable; no step occurs.
REQ-021 With rk_ready tied high, RUN lasts 51/59/67 cycles for 128/192/256. The first rk_valid is the cycle after the start edge.
REQ-022 start is ignored while busy. sel and last_key changes after the start edge have no effect.
REQ-023 done=1 only in DONE; busy=1 in RUN and DONE.

Reset
REQ-024 reset=0 at a clock edge forces IDLE. It also forces rk_valid=0, done=0, busy=0, round_idx=0 and round_key=0, in any state, including mid-RUN (the run is aborted with no further outputs).
REQ-025 reset takes priority over start in the same cycle.
REQ-026 Window, phase and rcon_idx registers need not be cleared; they are reloaded on start.

Verification
REQ-027 AES-128: sel=00, last_key[127:0]=13111d7fe3944a17f307a78b4d2b30c5, rk_ready=1 -> round 10 = that value the cycle after start; round 0 = 000102030405060708090a0b0c0d0e0f 50 cycles later; done pulses once.
REQ-028 AES-256: sel=10, last_key = 4e5a6699a9f24fe07e572baacdf8cdea||24fc79ccbf0979e9371ac23c6d68de36 -> first output idx 14 = 24fc79cc...de36, idx 13 = 4e5a...cdea, idx 0 = 000102030405060708090a0b0c0d0e0f.
REQ-029 AES-192: last_key = words 46..51 from KeyExpansion #(6,12) of 000102...1617 -> all 13 round keys equal the forward expansion slices in reverse order; idx 0 = 000102030405060708090a0b0c0d0e0f.
REQ-030 Backpressure: random rk_ready -> the output sequence is identical to the rk_ready=1 run; values stay stable while rk_valid=1 and rk_ready=0.
REQ-031 reset=0 asserted at idx 5 of a 128 run -> next cycle busy=0 and rk_valid=0; a new start yields the full sequence from idx 10.
REQ-032 start pulsed mid-run with a different sel -> ignored; the run completes unchanged.

Source files
------------

// File: rtl/aes_inv_key_schedule_if.sv
// Handshake/data bundle between a consumer and the inverse AES key schedule.
// The master side requests a run and accepts round keys; the slave side is the schedule.
interface aes_inv_key_schedule_if;
  logic [1:0]   sel;
  logic         start;
  logic [255:0] last_key;
  logic         rk_ready;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  modport master (
    output sel, start, last_key, rk_ready,
    input  rk_valid, round_key, round_idx, busy, done
  );

  modport slave (
    input  sel, start, last_key, rk_ready,
    output rk_valid, round_key, round_idx, busy, done
  );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// Inverse AES key schedule: starting from the last Nk words of the expanded key,
// walks the expansion backwards one word per cycle and hands out round keys
// from round Nr down to round 0 over a valid/ready handshake.
module aes_inv_key_schedule (
  input logic                     clk,
  input logic                     reset,
  aes_inv_key_schedule_if.slave   bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  // Forward AES S-box (the backward recurrence still uses SubWord, not its inverse).
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Key size code: 0 = AES-128, 1 = AES-192, 2 = AES-256.
  state_t       r_state;
  state_t       w_state_next;
  logic [1:0]   r_ks;
  logic [31:0]  r_win [8];     // r_win[k] holds expanded word w[j+k]
  logic [5:0]   r_j;           // index of the oldest word held in the window
  logic [3:0]   r_round;       // round whose key is presented next
  logic [2:0]   r_phase;       // (index of the word being recovered) mod Nk
  logic [3:0]   r_rcon_idx;

  logic [1:0]   w_ks_in;
  logic         w_start_fire;
  logic [5:0]   w_round_x4;
  logic         w_rk_valid;
  logic         w_fire;
  logic         w_step;
  logic [2:0]   w_o0, w_o1, w_o2, w_o3;
  logic [5:0]   w_j0;
  logic [3:0]   w_nr;
  logic [3:0]   w_rc0;
  logic [2:0]   w_nk_m1;
  logic [31:0]  w_top;
  logic [31:0]  w_prev;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_t;
  logic [31:0]  w_new;
  logic         w_busy;
  logic         w_done;
  logic [31:0]  w_load [8];

  assign w_ks_in      = bus.sel[1] ? 2'd2 : bus.sel;
  assign w_start_fire = (r_state == ST_IDLE) && bus.start;
  assign w_round_x4   = {r_round, 2'b00};
  assign w_rk_valid   = (r_state == ST_RUN) && (r_j <= w_round_x4);
  assign w_fire       = w_rk_valid && bus.rk_ready;
  assign w_step       = (r_state == ST_RUN) && !w_rk_valid;

  // The offset 4r-j never exceeds 4, so modulo-8 arithmetic on the low bits is exact.
  assign w_o0 = {r_round[0], 2'b00} - r_j[2:0];
  assign w_o1 = w_o0 + 3'd1;
  assign w_o2 = w_o0 + 3'd2;
  assign w_o3 = w_o0 + 3'd3;

  // Right-aligned last_key unpacked into window words for each key size.
  for (genvar gi = 0; gi < 8; gi++) begin : g_load
    logic [31:0] w_l128;
    logic [31:0] w_l192;
    logic [31:0] w_l256;
    if (gi < 4) begin : g_128
      assign w_l128 = bus.last_key[127-32*gi -: 32];
    end else begin : g_128_none
      assign w_l128 = '0;
    end
    if (gi < 6) begin : g_192
      assign w_l192 = bus.last_key[191-32*gi -: 32];
    end else begin : g_192_none
      assign w_l192 = '0;
    end
    assign w_l256     = bus.last_key[255-32*gi -: 32];
    assign w_load[gi] = (w_ks_in == 2'd0) ? w_l128 :
                        (w_ks_in == 2'd1) ? w_l192 : w_l256;
  end

  // Per-size start values for the word index, round counter and Rcon index.
  always_comb begin
    w_j0  = 6'd52;
    w_nr  = 4'd14;
    w_rc0 = 4'd7;
    case (w_ks_in)
      2'd0: begin w_j0 = 6'd40; w_nr = 4'd10; w_rc0 = 4'd10; end
      2'd1: begin w_j0 = 6'd46; w_nr = 4'd12; w_rc0 = 4'd8;  end
      default: ;
    endcase
  end

  // Select the two window words the backward recurrence needs for the latched size.
  always_comb begin
    w_nk_m1 = 3'd7;
    w_top   = r_win[7];
    w_prev  = r_win[6];
    case (r_ks)
      2'd0: begin w_nk_m1 = 3'd3; w_top = r_win[3]; w_prev = r_win[2]; end
      2'd1: begin w_nk_m1 = 3'd5; w_top = r_win[5]; w_prev = r_win[4]; end
      default: ;
    endcase
  end

  // T(x) and the recovered word w[j-1] = w[j-1+Nk] xor T(w[j-2+Nk]).
  always_comb begin
    w_sub_in  = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    w_sub_out = sub_word(w_sub_in);
    if (r_phase == 3'd0) begin
      w_t = w_sub_out ^ {rcon(r_rcon_idx), 24'h0};
    end else if (r_ks == 2'd2 && r_phase == 3'd4) begin
      w_t = w_sub_out;
    end else begin
      w_t = w_prev;
    end
    w_new = w_top ^ w_t;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_busy = 1'b1;
        if (w_fire && r_round == 4'd0) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_busy       = 1'b1;
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Datapath: load on start, count rounds on handshake, otherwise step one word back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_round <= 4'd0;
      r_j     <= 6'd0;
    end else if (w_start_fire) begin
      r_ks       <= w_ks_in;
      r_j        <= w_j0;
      r_round    <= w_nr;
      r_phase    <= 3'd3;
      r_rcon_idx <= w_rc0;
      for (int k = 0; k < 8; k++) r_win[k] <= w_load[k];
    end else if (w_fire) begin
      r_round <= r_round - 4'd1;
    end else if (w_step) begin
      r_win[0] <= w_new;
      for (int k = 1; k < 8; k++) r_win[k] <= r_win[k-1];
      r_j     <= r_j - 6'd1;
      r_phase <= (r_phase == 3'd0) ? w_nk_m1 : r_phase - 3'd1;
      if (r_phase == 3'd0) r_rcon_idx <= r_rcon_idx - 4'd1;
    end
  end

  assign bus.rk_valid  = w_rk_valid;
  assign bus.round_key = w_rk_valid ? {r_win[w_o0], r_win[w_o1], r_win[w_o2], r_win[w_o3]} : 128'h0;
  assign bus.round_idx = w_rk_valid ? r_round : 4'd0;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

endmodule
